// File: rtl/main_memory_responder_if.sv
// Cache <-> main-store bus: byte-serial write-back stream in, block refill stream out.
// master = cache side, slave = main_memory_responder.
interface main_memory_responder_if #(
    parameter int unsigned ADDR_SIZE = 16,
    parameter int unsigned WORD_SIZE = 16
);
    logic                 wb_valid;
    logic [ADDR_SIZE-1:0] wb_addr;
    logic [7:0]           wb_byte;
    logic                 wb_ready;
    logic                 refill_req;
    logic [ADDR_SIZE-1:0] refill_addr;
    logic [WORD_SIZE-1:0] refill_word;
    logic                 refill_word_valid;
    logic                 refill_done;
    logic                 busy;
    logic                 proto_err;

    modport master (
        output wb_valid, wb_addr, wb_byte, refill_req, refill_addr,
        input  wb_ready, refill_word, refill_word_valid, refill_done, busy, proto_err
    );

    modport slave (
        input  wb_valid, wb_addr, wb_byte, refill_req, refill_addr,
        output wb_ready, refill_word, refill_word_valid, refill_done, busy, proto_err
    );
endinterface

// File: rtl/main_memory_responder.sv
// Main-store endpoint: commits write-back bytes into a word array and streams block refills
// after MEM_LATENCY idle cycles. Optional protocol checker: define MEMRESP_PROTO_CHECK_EN.
module main_memory_responder #(
    parameter int unsigned ADDR_SIZE   = 16,
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned BLOCK_SIZE  = 8,
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned MEM_WORDS   = 2 ** (ADDR_SIZE - 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    main_memory_responder_if.slave bus
);
    localparam int unsigned WA_W     = ADDR_SIZE - 1;
    localparam int unsigned IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned OFF_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int unsigned LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned LAT_LAST = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STREAM} state_e;

    state_e               state_q;
    logic                 pending_q;
    logic [WA_W-1:0]      base_q;
    logic [LAT_W-1:0]     cnt_q;
    logic [OFF_W-1:0]     widx_q;
    logic                 wb_ready_q;
    logic [WORD_SIZE-1:0] word_q;
    logic                 valid_q;
    logic                 done_q;
    logic                 busy_q;

    logic [WORD_SIZE-1:0] mem_q [MEM_WORDS];

    logic                 wb_fire;
    logic                 refill_cap;
    logic [WA_W-1:0]      wb_wa;
    logic [WA_W-1:0]      refill_base;
    logic [WA_W-1:0]      rd_wa;

    function automatic logic [IDX_W-1:0] word_idx(input logic [WA_W-1:0] wa);
        return IDX_W'(32'(wa) % MEM_WORDS);
    endfunction

    assign wb_fire     = bus.wb_valid & wb_ready_q;
    assign refill_cap  = bus.refill_req & ~busy_q;
    assign wb_wa       = WA_W'(bus.wb_addr >> 1);
    assign refill_base = WA_W'(bus.refill_addr >> 1) & ~WA_W'(BLOCK_SIZE - 1);
    // Base has its offset bits cleared, so OR-ing the word index never carries into the block.
    assign rd_wa       = base_q | WA_W'(widx_q);

    // Backing array: not reset, byte-lane writes only.
    always_ff @(posedge clk) begin
        if (wb_fire) begin
            if (bus.wb_addr[0]) mem_q[word_idx(wb_wa)][15:8] <= bus.wb_byte;
            else                mem_q[word_idx(wb_wa)][7:0]  <= bus.wb_byte;
        end
    end

    // Refill sequencer; busy/wb_ready stay asserted through the refill_done cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            base_q     <= '0;
            cnt_q      <= '0;
            widx_q     <= '0;
            wb_ready_q <= 1'b1;
            word_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (refill_cap) base_q <= refill_base;
            case (state_q)
                ST_IDLE: begin
                    if (wb_fire) begin
                        pending_q  <= pending_q | refill_cap;
                        busy_q     <= pending_q | refill_cap;
                        wb_ready_q <= 1'b1;
                    end else if (pending_q || refill_cap) begin
                        state_q    <= (MEM_LATENCY == 0) ? ST_STREAM : ST_WAIT;
                        pending_q  <= 1'b0;
                        cnt_q      <= '0;
                        widx_q     <= '0;
                        busy_q     <= 1'b1;
                        wb_ready_q <= 1'b0;
                    end else begin
                        busy_q     <= 1'b0;
                        wb_ready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + LAT_W'(1);
                    if (cnt_q == LAT_W'(LAT_LAST)) state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    word_q  <= mem_q[word_idx(rd_wa)];
                    valid_q <= 1'b1;
                    done_q  <= (widx_q == OFF_W'(BLOCK_SIZE - 1));
                    widx_q  <= widx_q + OFF_W'(1);
                    if (widx_q == OFF_W'(BLOCK_SIZE - 1)) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.wb_ready          = wb_ready_q;
    assign bus.refill_word       = word_q;
    assign bus.refill_word_valid = valid_q;
    assign bus.refill_done       = done_q;
    assign bus.busy              = busy_q;

`ifdef MEMRESP_PROTO_CHECK_EN
    logic                 proto_err_q;
    logic                 stall_q;
    logic [ADDR_SIZE-1:0] stall_addr_q;
    logic [7:0]           stall_byte_q;
    logic                 stall;

    assign stall = bus.wb_valid & ~wb_ready_q;

    // Sticky: refill strobe while busy, or a stalled write-back whose payload moved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err_q  <= 1'b0;
            stall_q      <= 1'b0;
            stall_addr_q <= '0;
            stall_byte_q <= '0;
        end else begin
            stall_q      <= stall;
            stall_addr_q <= bus.wb_addr;
            stall_byte_q <= bus.wb_byte;
            if ((bus.refill_req && busy_q) ||
                (stall && stall_q &&
                 ((bus.wb_addr != stall_addr_q) || (bus.wb_byte != stall_byte_q))))
                proto_err_q <= 1'b1;
        end
    end

    assign bus.proto_err = proto_err_q;
`else
    assign bus.proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: cycle-accurate vector table plus
// hand-written refill/stall/reset/protocol sequences.
module tb_main_memory_responder;
    localparam int unsigned ADDR_SIZE  = 16;
    localparam int unsigned WORD_SIZE  = 16;
    localparam int unsigned BLOCK_SIZE = 8;
`ifdef MEMRESP_PROTO_CHECK_EN
    localparam int unsigned LAT      = 0;
    localparam logic        PROTO_ON = 1'b1;
`else
    localparam int unsigned LAT      = 2;
    localparam logic        PROTO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    main_memory_responder_if #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE)) bus ();

    main_memory_responder #(
        .ADDR_SIZE  (ADDR_SIZE),
        .WORD_SIZE  (WORD_SIZE),
        .BLOCK_SIZE (BLOCK_SIZE),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        wv;
        logic [15:0] wa;
        logic [7:0]  wd;
        logic        rq;
        logic [15:0] ra;
        logic        e_ready;
        logic        e_valid;
        logic        e_done;
        logic        e_busy;
        logic        chk_word;
        logic [15:0] e_word;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic wv, logic [15:0] wa, logic [7:0] wd, logic rq,
                                logic [15:0] ra, logic e_ready, logic e_valid, logic e_done,
                                logic e_busy, logic chk_word, logic [15:0] e_word);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rq = rq; v.ra = ra;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_done = e_done; v.e_busy = e_busy;
        v.chk_word = chk_word; v.e_word = e_word;
        vecs.push_back(v);
    endfunction

    function automatic logic [15:0] blk1230_word(int k);
        return 16'(((2 * k + 1) << 8) | (2 * k));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_byte = '0;
        bus.refill_req = 1'b0; bus.refill_addr = '0;
    endtask

    task automatic start_refill(input logic [15:0] a);
        bus.refill_req = 1'b1; bus.refill_addr = a;
        tick();
        bus.refill_req = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int g = 0;
        while (!bus.refill_word_valid && g < 40) begin tick(); g++; end
        if (!bus.refill_word_valid) begin
            n_cmp++; n_err++;
            $display("FAIL %s: timeout waiting for refill_word_valid", nm);
        end
    endtask

    task automatic wait_done(input string nm);
        int g = 0;
        while (!bus.refill_done && g < 40) begin tick(); g++; end
        if (!bus.refill_done) begin
            n_cmp++; n_err++;
            $display("FAIL %s: timeout waiting for refill_done", nm);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int g;
        reset = 1'b0;
        idle_inputs();

        // Table: 16 bytes then refill of 0x1235; then write stream stalling a pulsed refill.
        for (int i = 0; i < 16; i++)
            add(1'b1, 16'h1230 + 16'(i), 8'(i), 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        add(1'b0, 16'h0, 8'h0, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < int'(LAT); i++)
            add(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 8; k++)
            add(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b1, (k == 7), 1'b1, 1'b1, blk1230_word(k));
        add(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

        add(1'b1, 16'h2000, 8'h11, 1'b1, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        add(1'b1, 16'h2001, 8'h22, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        add(1'b1, 16'h2002, 8'h33, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        add(1'b1, 16'h2003, 8'h44, 1'b0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        add(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < int'(LAT); i++)
            add(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        add(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2211);
        add(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4433);
        for (int k = 2; k < 8; k++)
            add(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b1, (k == 7), 1'b1, 1'b0, 16'h0);
        add(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

        // Reset values (asynchronous, before any clock edge).
        #2 pulse_reset();
        chk("rst wb_ready", 32'(bus.wb_ready), 32'd1);
        chk("rst valid", 32'(bus.refill_word_valid), 32'd0);
        chk("rst done", 32'(bus.refill_done), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst word", 32'(bus.refill_word), 32'd0);
        chk("rst proto_err", 32'(bus.proto_err), 32'd0);
        tick();
        tick();
        release_reset();

        foreach (vecs[i]) begin
            bus.wb_valid = vecs[i].wv; bus.wb_addr = vecs[i].wa; bus.wb_byte = vecs[i].wd;
            bus.refill_req = vecs[i].rq; bus.refill_addr = vecs[i].ra;
            tick();
            chk($sformatf("vec%0d wb_ready", i), 32'(bus.wb_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d valid", i), 32'(bus.refill_word_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d done", i), 32'(bus.refill_done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
            if (vecs[i].chk_word)
                chk($sformatf("vec%0d word", i), 32'(bus.refill_word), 32'(vecs[i].e_word));
        end
        idle_inputs();
        chk("table proto_err", 32'(bus.proto_err), 32'd0);

        // Write-back offered during STREAM is held off until after refill_done.
        bus.wb_valid = 1'b1; bus.wb_addr = 16'h0041; bus.wb_byte = 8'h5B;
        tick();
        bus.wb_valid = 1'b0;
        start_refill(16'h1230);
        wait_valid("t3 first stream");
        bus.wb_valid = 1'b1; bus.wb_addr = 16'h0040; bus.wb_byte = 8'hAA;
        g = 0;
        while (g < 40) begin
            chk("t3 wb_ready low in stream", 32'(bus.wb_ready), 32'd0);
            if (bus.refill_done) break;
            tick();
            g++;
        end
        tick();
        chk("t3 wb_ready after done", 32'(bus.wb_ready), 32'd1);
        chk("t3 busy after done", 32'(bus.busy), 32'd0);
        tick();
        bus.wb_valid = 1'b0;
        start_refill(16'h0040);
        wait_valid("t3 second stream");
        chk("t3 merged word", 32'(bus.refill_word), 32'h5BAA);
        wait_done("t3 second stream");
        tick();

        // Reset at the 3rd streamed word aborts the stream; array contents survive.
        start_refill(16'h1230);
        wait_valid("t4 stream");
        tick();
        tick();
        chk("t4 third word", 32'(bus.refill_word), 32'(blk1230_word(2)));
        pulse_reset();
        chk("t4 valid on reset", 32'(bus.refill_word_valid), 32'd0);
        chk("t4 done on reset", 32'(bus.refill_done), 32'd0);
        chk("t4 busy on reset", 32'(bus.busy), 32'd0);
        chk("t4 wb_ready on reset", 32'(bus.wb_ready), 32'd1);
        release_reset();
        start_refill(16'h1230);
        wait_valid("t4 re-read");
        chk("t4 persist word0", 32'(bus.refill_word), 32'(blk1230_word(0)));
        tick();
        chk("t4 persist word1", 32'(bus.refill_word), 32'(blk1230_word(1)));
        wait_done("t4 re-read");
        tick();

        // Refill strobe while busy: ignored, flagged when checking is built in.
        chk("t5 proto_err before", 32'(bus.proto_err), 32'd0);
        bus.refill_req = 1'b1; bus.refill_addr = 16'h1230;
        tick();
        bus.refill_addr = 16'h0040;
        tick();
        bus.refill_req = 1'b0;
        chk("t5 proto_err busy strobe", 32'(bus.proto_err), 32'(PROTO_ON));
        chk("t5 busy", 32'(bus.busy), 32'd1);
        n = 0;
        g = 0;
        while (g < 40) begin
            if (bus.refill_word_valid) begin
                chk($sformatf("t5 word%0d", n), 32'(bus.refill_word), 32'(blk1230_word(n)));
                n++;
                if (bus.refill_done) break;
            end
            tick();
            g++;
        end
        chk("t5 word count", 32'(n), 32'd8);
        tick();
        chk("t5 busy after", 32'(bus.busy), 32'd0);
        chk("t5 proto_err sticky", 32'(bus.proto_err), 32'(PROTO_ON));
        tick();
        tick();
        chk("t5 no second refill", 32'(bus.refill_word_valid), 32'd0);
        pulse_reset();
        chk("t5 proto_err cleared", 32'(bus.proto_err), 32'd0);
        release_reset();

        // Stalled write-back whose payload changes while wb_ready=0.
        start_refill(16'h1230);
        bus.wb_valid = 1'b1; bus.wb_addr = 16'h0050; bus.wb_byte = 8'h01;
        tick();
        chk("t6 proto_err stable stall", 32'(bus.proto_err), 32'd0);
        bus.wb_byte = 8'h02;
        tick();
        chk("t6 proto_err payload change", 32'(bus.proto_err), 32'(PROTO_ON));
        wait_done("t6 stream");
        tick();
        tick();
        bus.wb_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Main-store-side endpoint for the data cache's memory traffic. It accepts the byte-serial write-back stream produced by the cache's write-back buffer and commits each byte to a word-organised backing array. It also services block refill requests by streaming `BLOCK_SIZE` consecutive words into the cache's block (refill) buffer after a programmable latency. Write-back bytes always win arbitration over a pending refill, so a refill never reads stale data.

## Interface
- `ADDR_SIZE`, 16, byte address width
- `WORD_SIZE`, 16, word width; fixed to two bytes
- `BLOCK_SIZE`, 8, words per cache block; power of two
- `MEM_LATENCY`, 2, idle cycles between refill start and first word; 0 allowed
- `MEM_WORDS`, 2**(ADDR_SIZE-1), backing array depth in words

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `wb_valid`  in  1  write-back byte offered
- `wb_addr`  in  ADDR_SIZE  byte address of offered byte
- `wb_byte`  in  8  byte data
- `wb_ready`  out  1  byte accepted on an edge where `wb_valid & wb_ready`
- `refill_req`  in  1  single-cycle refill strobe
- `refill_addr`  in  ADDR_SIZE  any byte address inside the requested block
- `refill_word`  out  WORD_SIZE  streamed refill word
- `refill_word_valid`  out  1  `refill_word` valid; drives the block buffer write strobe
- `refill_done`  out  1  high with the last word of a block
- `busy`  out  1  refill pending or in progress
- `proto_err`  out  1  sticky protocol-violation flag

## Operation
- Word address: `addr[ADDR_SIZE-1:1]`, modulo `MEM_WORDS`.
- Byte lane: `addr[0]=0` selects bits `[7:0]`; `addr[0]=1` selects bits `[15:8]`.
- Byte writes update only the addressed lane.
- Refill base: the `refill_addr` word address with its low `log2(BLOCK_SIZE)` bits cleared.
- The array is not cleared by reset.
- `refill_req` while not busy captures the base address and sets `pending`.
- `refill_req` while busy is ignored and recorded as an error.
- FSM states: `IDLE`, `WAIT`, `STREAM`.
- `IDLE`:
  - `wb_ready=1`.
  - If `wb_valid`, write the byte and stay in `IDLE`. This takes priority over refill.
  - Otherwise, if `pending` (or `refill_req` arriving on this edge), go to `WAIT`, or to `STREAM` when `MEM_LATENCY=0`.
  - On leaving, clear `pending` and clear the latency/word counters.
- `WAIT`:
  - `wb_ready=0`.
  - Count `MEM_LATENCY` cycles, then go to `STREAM`.
- `STREAM`:
  - `wb_ready=0`.
  - Word k (0..BLOCK_SIZE-1) of the block is presented in the k-th cycle, with `refill_word_valid=1`.
  - `refill_done=1` only in the cycle with k=BLOCK_SIZE-1; the FSM then returns to `IDLE`.
  - Word index wraps within the block; it never carries into the block index.
- `busy = pending | (state != IDLE)`.

## Timing
- Reset values: `IDLE`, `pending=0`, `wb_ready=1`.
- All other outputs reset to 0: `refill_word`, `refill_word_valid`, `refill_done`, `busy`, `proto_err`.
- Byte write latency: the write is committed at the accepting edge. A refill starting one cycle later sees it.
- Back-to-back bytes are accepted one per cycle with no bubble.
- Refill timing, with start edge Es (the `IDLE` → `WAIT`/`STREAM` transition):
  - `busy` is 1 from the cycle after `refill_req` is captured until the cycle after `refill_done`.
  - Cycles Es+1 .. Es+MEM_LATENCY: no valid word.
  - Cycles Es+MEM_LATENCY+1 .. Es+MEM_LATENCY+BLOCK_SIZE: words 0..BLOCK_SIZE-1.
  - `wb_ready` returns to 1 in the cycle after `refill_done`.
- Unstalled refill (`refill_req` in `IDLE`, `wb_valid=0`): first word appears MEM_LATENCY+1 cycles after the strobe edge.
- `refill_word_valid` and `refill_done` deassert in the cycle after the last word.
- Reset mid-refill: the stream is aborted immediately and all outputs take their reset values. Bytes already written persist.

## Configuration
- `MEMRESP_PROTO_CHECK_EN`, when defined, sets `proto_err` (cleared only by reset) on either of:
  - `refill_req` while `busy`;
  - `wb_addr` or `wb_byte` changing between consecutive cycles while `wb_valid=1 & wb_ready=0`.
- When undefined, `proto_err` is tied to 0 and no checking logic is generated.

## Test plan
- Write 16 bytes to addresses 0x1230–0x123F with values 0x00..0x0F, then `refill_req` with `refill_addr=0x1235`.
  - Expected: words 0x0100, 0x0302, … 0x0F0E on consecutive valid cycles.
  - Expected: first word at strobe edge +3 (`MEM_LATENCY=2`); `refill_done` with the 8th word.
- Hold `wb_valid` for 4 cycles while `refill_req` is pulsed.
  - Expected: all 4 bytes accepted; `busy=1`; refill starts on the first edge with `wb_valid=0`.
- During `STREAM`, assert `wb_valid` (addr 0x0040, byte 0xAA).
  - Expected: `wb_ready=0` until the cycle after `refill_done`, then accepted.
  - Expected: a later refill of 0x0040 returns 0x??AA, with the upper byte unchanged.
- Reset asserted at the 3rd streamed word.
  - Expected: `refill_word_valid`, `refill_done`, `busy` = 0 immediately; `wb_ready=1`.
  - Expected: earlier written data still reads back.
- With `MEMRESP_PROTO_CHECK_EN` defined and `MEM_LATENCY=0`:
  - Second `refill_req` while busy → `proto_err=1` until reset; the original refill completes unaffected.
  - First word appears 1 cycle after the strobe.
